// File: rtl/reg_file_mp.sv
// Multi-ported register file with a pending-writeback scoreboard.
// Reads are registered, with write-first bypass. Write port 1 beats port 0.
// The scoreboard is advisory only and never blocks reads or writes.

// One read port: a write-first bypass mux, registered data and a combinational busy flag.
module reg_file_mp_rdport #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int NWRITE  = 1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [AW-1:0]                  addr_i,
  input  logic [NREGS-1:0][XLEN-1:0]     regs_i,
  input  logic [NREGS-1:0]               pend_i,
  input  logic [NWRITE-1:0]              wr_en_i,
  input  logic [NWRITE-1:0][AW-1:0]      wr_addr_i,
  input  logic [NWRITE-1:0][XLEN-1:0]    wr_data_i,
  output logic [XLEN-1:0]                data_o,
  output logic                           busy_o
);
  logic [XLEN-1:0] data_d, data_q;
  logic            hit;

  // Pick the stored value, then let same-cycle writes override it in port
  // order, so the highest-numbered port wins.
  always_comb begin
    data_d = regs_i[addr_i];
    hit    = 1'b0;
    for (int w = 0; w < NWRITE; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w] == addr_i)) begin
        data_d = wr_data_i[w];
        hit    = 1'b1;
      end
    end
    if (ZERO_R0 && (addr_i == '0)) data_d = '0;
    // A writeback landing this cycle retires the hazard, so it is not reported busy.
    busy_o = pend_i[addr_i] & ~hit;
  end

  // Register the selected read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

module reg_file_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int NREAD   = 2,
  parameter int NWRITE  = 1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  input  logic [NWRITE*XLEN-1:0]  wr_data,
  input  logic                    pend_set,
  input  logic [AW-1:0]           pend_addr,
  output logic [AW:0]             pend_count
);
  logic [NREAD-1:0][AW-1:0]     rd_addr_a;
  logic [NREAD-1:0][XLEN-1:0]   rd_data_a;
  logic [NWRITE-1:0][AW-1:0]    wr_addr_a;
  logic [NWRITE-1:0][XLEN-1:0]  wr_data_a;

  logic [NREGS-1:0][XLEN-1:0]   regs_d, regs_q;
  logic [NREGS-1:0]             pend_d, pend_q;
  logic [AW:0]                  cnt_d, cnt_q;

  assign rd_addr_a  = rd_addr;
  assign wr_addr_a  = wr_addr;
  assign wr_data_a  = wr_data;
  assign rd_data    = rd_data_a;
  assign pend_count = cnt_q;

  // Next storage state: apply writes in port order so port 1 wins a same-address
  // collision; register 0 stays hardwired to zero when enabled.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWRITE; w++) begin
      if (wr_en[w] && !(ZERO_R0 && (wr_addr_a[w] == '0)))
        regs_d[wr_addr_a[w]] = wr_data_a[w];
    end
  end

  // Next scoreboard state: clears first, then a set, so the set wins a tie.
  // The count is taken from the next state so it tracks the bits it reports.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < NWRITE; w++) begin
      if (wr_en[w]) pend_d[wr_addr_a[w]] = 1'b0;
    end
    if (pend_set) pend_d[pend_addr] = 1'b1;
    if (ZERO_R0) pend_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
  end

  // Storage, pending bits and count; reset drops everything, including in-flight writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    reg_file_mp_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NWRITE(NWRITE), .ZERO_R0(ZERO_R0)
    ) u_rd (
      .clk       (clk),
      .reset     (reset),
      .addr_i    (rd_addr_a[r]),
      .regs_i    (regs_q),
      .pend_i    (pend_q),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr_a),
      .wr_data_i (wr_data_a),
      .data_o    (rd_data_a[r]),
      .busy_o    (rd_busy[r])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: 2 read ports, 2 write ports, r0 hardwired to zero.
module tb_reg_file_mp;
  localparam int XLEN = 32, AW = 5, NREAD = 2, NWRITE = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREAD*AW-1:0]     rd_addr;
  logic [NREAD*XLEN-1:0]   rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic [NWRITE-1:0]       wr_en;
  logic [NWRITE*AW-1:0]    wr_addr;
  logic [NWRITE*XLEN-1:0]  wr_data;
  logic                    pend_set;
  logic [AW-1:0]           pend_addr;
  logic [AW:0]             pend_count;

  int nvec = 0;
  int nerr = 0;

  reg_file_mp #(.XLEN(XLEN), .NREGS(32), .AW(AW), .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_R0(1'b1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_count(pend_count)
  );

  always #5 clk = ~clk;

  wire [XLEN-1:0] rd0 = rd_data[0*XLEN +: XLEN];
  wire [XLEN-1:0] rd1 = rd_data[1*XLEN +: XLEN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p]             = en;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic idle();
    wr_en    = '0;
    pend_set = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0;
    #12;
    nvec++; if (rd_data !== '0) begin nerr++; $display("FAIL reset_rd_data: got %h exp 0", rd_data); end
    nvec++; if (pend_count !== '0) begin nerr++; $display("FAIL reset_pend_count: got %0d exp 0", pend_count); end
    nvec++; if (rd_busy !== '0) begin nerr++; $display("FAIL reset_rd_busy: got %b exp 00", rd_busy); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd5;
    tick();
    nvec++; if (rd0 !== 32'hDEADBEEF) begin nerr++; $display("FAIL write_read_x5: got %h exp deadbeef", rd0); end
  endtask

  task automatic test_bypass();
    set_wr(0, 1'b1, 5'd7, 32'h12345678);
    rd_addr[AW +: AW] = 5'd7;
    tick();
    nvec++; if (rd1 !== 32'h12345678) begin nerr++; $display("FAIL bypass_x7: got %h exp 12345678", rd1); end
    idle();
    tick();
    nvec++; if (rd1 !== 32'h12345678) begin nerr++; $display("FAIL stored_x7: got %h exp 12345678", rd1); end
  endtask

  task automatic test_write_conflict();
    set_wr(0, 1'b1, 5'd3, 32'h1);
    set_wr(1, 1'b1, 5'd3, 32'h2);
    rd_addr[0 +: AW] = 5'd3;
    tick();
    nvec++; if (rd0 !== 32'h2) begin nerr++; $display("FAIL conflict_bypass_x3: got %h exp 2", rd0); end
    idle();
    rd_addr[AW +: AW] = 5'd3;
    tick();
    nvec++; if (rd0 !== 32'h2) begin nerr++; $display("FAIL conflict_stored_x3: got %h exp 2", rd0); end
    nvec++; if (rd1 !== 32'h2) begin nerr++; $display("FAIL same_addr_port1_x3: got %h exp 2", rd1); end
  endtask

  task automatic test_zero_r0();
    set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    rd_addr[0 +: AW] = 5'd0;
    tick();
    nvec++; if (rd0 !== 32'h0) begin nerr++; $display("FAIL x0_bypass: got %h exp 0", rd0); end
    idle();
    tick();
    nvec++; if (rd0 !== 32'h0) begin nerr++; $display("FAIL x0_stored: got %h exp 0", rd0); end
    pend_set = 1'b1; pend_addr = 5'd0;
    tick();
    idle();
    nvec++; if (pend_count !== 6'd0) begin nerr++; $display("FAIL x0_pend_count: got %0d exp 0", pend_count); end
    nvec++; if (rd_busy[0] !== 1'b0) begin nerr++; $display("FAIL x0_busy: got %b exp 0", rd_busy[0]); end
  endtask

  task automatic test_scoreboard();
    pend_set = 1'b1; pend_addr = 5'd4;
    tick();
    pend_addr = 5'd9;
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd4;
    rd_addr[AW +: AW] = 5'd9;
    #1;
    nvec++; if (pend_count !== 6'd2) begin nerr++; $display("FAIL pend_two: got %0d exp 2", pend_count); end
    nvec++; if (rd_busy !== 2'b11) begin nerr++; $display("FAIL busy_x4_x9: got %b exp 11", rd_busy); end
    // Writeback to x4 together with a fresh set of x4.
    set_wr(0, 1'b1, 5'd4, 32'hA4);
    pend_set = 1'b1; pend_addr = 5'd4;
    #1;
    nvec++; if (rd_busy[0] !== 1'b0) begin nerr++; $display("FAIL busy_same_cycle_wb: got %b exp 0", rd_busy[0]); end
    tick();
    idle();
    #1;
    nvec++; if (pend_count !== 6'd2) begin nerr++; $display("FAIL set_beats_clear: got %0d exp 2", pend_count); end
    nvec++; if (rd_busy[0] !== 1'b1) begin nerr++; $display("FAIL x4_still_busy: got %b exp 1", rd_busy[0]); end
    // Re-setting a pending bit changes nothing.
    pend_set = 1'b1; pend_addr = 5'd9;
    tick();
    idle();
    nvec++; if (pend_count !== 6'd2) begin nerr++; $display("FAIL reset_pending_idem: got %0d exp 2", pend_count); end
    set_wr(1, 1'b1, 5'd9, 32'h99);
    tick();
    idle();
    nvec++; if (pend_count !== 6'd1) begin nerr++; $display("FAIL clear_x9: got %0d exp 1", pend_count); end
    nvec++; if (rd_busy[1] !== 1'b0) begin nerr++; $display("FAIL x9_not_busy: got %b exp 0", rd_busy[1]); end
    // Clearing a non-pending register changes nothing.
    set_wr(0, 1'b1, 5'd12, 32'h12);
    tick();
    idle();
    nvec++; if (pend_count !== 6'd1) begin nerr++; $display("FAIL clear_nonpending: got %0d exp 1", pend_count); end
  endtask

  task automatic test_async_reset();
    set_wr(0, 1'b1, 5'd1, 32'h11);
    set_wr(1, 1'b1, 5'd2, 32'h22);
    tick();
    idle();
    set_wr(0, 1'b1, 5'd3, 32'h33);
    pend_set = 1'b1; pend_addr = 5'd2;
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd2;
    rd_addr[AW +: AW] = 5'd3;
    tick();
    nvec++; if (rd0 !== 32'h22) begin nerr++; $display("FAIL pre_reset_x2: got %h exp 22", rd0); end
    nvec++; if (rd1 !== 32'h33) begin nerr++; $display("FAIL pre_reset_x3: got %h exp 33", rd1); end
    nvec++; if (pend_count !== 6'd2) begin nerr++; $display("FAIL pre_reset_count: got %0d exp 2", pend_count); end
    nvec++; if (rd_busy[0] !== 1'b1) begin nerr++; $display("FAIL pre_reset_busy_x2: got %b exp 1", rd_busy[0]); end
    // Assert reset mid-cycle with a write in flight.
    #2;
    set_wr(0, 1'b1, 5'd6, 32'hAA);
    pend_set = 1'b1; pend_addr = 5'd6;
    reset = 1'b1;
    #1;
    nvec++; if (rd_data !== '0) begin nerr++; $display("FAIL async_rd_data: got %h exp 0", rd_data); end
    nvec++; if (pend_count !== '0) begin nerr++; $display("FAIL async_pend_count: got %0d exp 0", pend_count); end
    nvec++; if (rd_busy !== '0) begin nerr++; $display("FAIL async_rd_busy: got %b exp 00", rd_busy); end
    tick();
    reset = 1'b0;
    idle();
    rd_addr[0 +: AW] = 5'd1;
    rd_addr[AW +: AW] = 5'd2;
    tick();
    nvec++; if (rd0 !== 32'h0) begin nerr++; $display("FAIL post_reset_x1: got %h exp 0", rd0); end
    nvec++; if (rd1 !== 32'h0) begin nerr++; $display("FAIL post_reset_x2: got %h exp 0", rd1); end
    rd_addr[0 +: AW] = 5'd3;
    rd_addr[AW +: AW] = 5'd6;
    tick();
    nvec++; if (rd0 !== 32'h0) begin nerr++; $display("FAIL post_reset_x3: got %h exp 0", rd0); end
    nvec++; if (rd1 !== 32'h0) begin nerr++; $display("FAIL post_reset_x6_dropped: got %h exp 0", rd1); end
    nvec++; if (pend_count !== 6'd0) begin nerr++; $display("FAIL post_reset_count: got %0d exp 0", pend_count); end
    // Normal operation resumes right away.
    set_wr(1, 1'b1, 5'd10, 32'h55);
    pend_set = 1'b1; pend_addr = 5'd11;
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd10;
    tick();
    nvec++; if (rd0 !== 32'h55) begin nerr++; $display("FAIL resume_x10: got %h exp 55", rd0); end
    nvec++; if (pend_count !== 6'd1) begin nerr++; $display("FAIL resume_count: got %0d exp 1", pend_count); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_write_conflict();
    test_zero_r0();
    test_scoreboard();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, exp finish before 100000");
    $fatal(1);
  end
endmodule
